// File: rtl/shift_pkg.sv
// shift_pkg: shared mode and FSM state encodings for univ_shift_reg
//   mode_e  : 3-bit operation select (6 and 7 are reserved and behave as HOLD)
//   state_e : serialiser burst FSM state
package shift_pkg;
   typedef enum logic [2:0] {
      HOLD = 3'd0,
      LOAD = 3'd1,
      SHL  = 3'd2,
      SHR  = 3'd3,
      ROL  = 3'd4,
      ROR  = 3'd5
   } mode_e;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;
endpackage

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with clock enable, shift/rotate and an MSB-first serialiser burst
//   clk, reset (async, active-high), en (clock enable for all state)
//   mode[2:0] operation select, d[WIDTH-1:0] parallel data, sin_r/sin_l serial inputs
//   start: begin a burst; q/qb register contents and complement; sout = q[WIDTH-1]
//   busy: burst shifting; done: one-cycle pulse after the last burst bit
module univ_shift_reg
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic             start,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             sout,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH);
   logic [WIDTH-1:0] reg_q, reg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   state_e           state_q, state_d;
   always_comb begin
      reg_d   = reg_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      if (en) begin
         case (state_q)
            IDLE:
               if (start) begin
                  reg_d   = d;
                  cnt_d   = CW'(WIDTH - 1);
                  state_d = SHIFT;
               end else begin
                  case (mode)
                     LOAD:    reg_d = d;
                     SHL:     reg_d = {reg_q[WIDTH-2:0], sin_r};
                     SHR:     reg_d = {sin_l, reg_q[WIDTH-1:1]};
                     ROL:     reg_d = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
                     ROR:     reg_d = {reg_q[0], reg_q[WIDTH-1:1]};
                     default: reg_d = reg_q;
                  endcase
               end
            SHIFT: begin
               // zero fill leaves q all zeros once the last bit has left
               reg_d   = {reg_q[WIDTH-2:0], 1'b0};
               state_d = (cnt_q == '0) ? DONE : SHIFT;
               cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_q   <= '0;
         cnt_q   <= '0;
         state_q <= IDLE;
      end else begin
         reg_q   <= reg_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end
   assign q    = reg_q;
   assign qb   = ~reg_q;
   assign sout = reg_q[WIDTH-1];
   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: table-driven and scoreboarded checks of univ_shift_reg at WIDTH=8
module tb_univ_shift_reg;
   import shift_pkg::*;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic [2:0] mode = 3'd0;
   logic [7:0] d = 8'h00;
   logic       sin_r = 1'b0;
   logic       sin_l = 1'b0;
   logic       start = 1'b0;
   logic [7:0] q, qb;
   logic       sout, busy, done;
   int n_cmp = 0;
   int n_err = 0;
   typedef struct {
      logic [7:0] q;
      logic       busy;
      logic       done;
   } exp_t;
   exp_t sb[$];
   typedef struct {
      logic [2:0] mode;
      logic [7:0] d;
      logic       sin_r;
      logic       sin_l;
      logic       en;
      logic [7:0] exp_q;
   } vec_t;
   vec_t vecs[20];
   univ_shift_reg #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
      .sin_r(sin_r), .sin_l(sin_l), .start(start),
      .q(q), .qb(qb), .sout(sout), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, want);
      end
   endtask
   task automatic check_all(input string nm, input exp_t e);
      check({nm, ".q"}, q, e.q);
      check({nm, ".qb"}, qb, ~e.q);
      check({nm, ".sout"}, 8'(sout), 8'(e.q[7]));
      check({nm, ".busy"}, 8'(busy), 8'(e.busy));
      check({nm, ".done"}, 8'(done), 8'(e.done));
   endtask
   task automatic step(input string nm, input logic [2:0] m, input logic [7:0] dv,
                       input logic sr, input logic sl, input logic e, input logic st,
                       input logic [7:0] eq, input logic eb, input logic ed);
      exp_t x;
      @(negedge clk);
      mode = m; d = dv; sin_r = sr; sin_l = sl; en = e; start = st;
      sb.push_back('{q: eq, busy: eb, done: ed});
      @(posedge clk);
      #1;
      x = sb.pop_front();
      check_all(nm, x);
   endtask
   task automatic burst(input logic [7:0] dv, input int stall_at, input int stall_n, input bit junk);
      step("burst0", 3'd0, dv, 1'b1, 1'b1, 1'b1, 1'b1, dv, 1'b1, 1'b0);
      for (int k = 1; k < 8; k++) begin
         if (k == stall_at)
            for (int s = 0; s < stall_n; s++)
               step("stall", LOAD, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 8'(dv << (k - 1)), 1'b1, 1'b0);
         step("burst", junk ? 3'(LOAD) : 3'(HOLD), junk ? ~dv : dv, 1'b1, 1'b1, 1'b1, junk,
              8'(dv << k), 1'b1, 1'b0);
      end
      step("done", 3'd0, dv, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      step("after", 3'd0, dv, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask
   initial begin
      vecs = '{
         '{3'(LOAD), 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5},
         '{3'(ROL),  8'h00, 1'b0, 1'b0, 1'b1, 8'h4B},
         '{3'(ROR),  8'h00, 1'b0, 1'b0, 1'b1, 8'hA5},
         '{3'(HOLD), 8'h3C, 1'b1, 1'b1, 1'b1, 8'hA5},
         '{3'd6,     8'h3C, 1'b1, 1'b1, 1'b1, 8'hA5},
         '{3'd7,     8'h3C, 1'b1, 1'b1, 1'b1, 8'hA5},
         '{3'(LOAD), 8'h00, 1'b0, 1'b0, 1'b1, 8'h00},
         '{3'(SHL),  8'h00, 1'b1, 1'b0, 1'b1, 8'h01},
         '{3'(SHL),  8'h00, 1'b1, 1'b0, 1'b1, 8'h03},
         '{3'(SHL),  8'h00, 1'b1, 1'b0, 1'b1, 8'h07},
         '{3'(LOAD), 8'hFF, 1'b0, 1'b0, 1'b0, 8'h07},
         '{3'(LOAD), 8'h00, 1'b0, 1'b0, 1'b1, 8'h00},
         '{3'(SHR),  8'h00, 1'b0, 1'b1, 1'b1, 8'h80},
         '{3'(SHR),  8'h00, 1'b0, 1'b1, 1'b1, 8'hC0},
         '{3'(SHL),  8'h00, 1'b0, 1'b1, 1'b1, 8'h80},
         '{3'(SHR),  8'h00, 1'b1, 1'b0, 1'b1, 8'h40},
         '{3'(ROR),  8'h00, 1'b1, 1'b1, 1'b1, 8'h20},
         '{3'(LOAD), 8'h01, 1'b0, 1'b0, 1'b1, 8'h01},
         '{3'(ROR),  8'h00, 1'b0, 1'b0, 1'b1, 8'h80},
         '{3'(ROL),  8'h00, 1'b0, 1'b0, 1'b1, 8'h01}
      };
      repeat (2) @(negedge clk);
      check_all("reset", '{q: 8'h00, busy: 1'b0, done: 1'b0});
      reset = 1'b0;
      // asynchronous reset between edges
      step("preload", 3'(LOAD), 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1 check_all("async_rst", '{q: 8'h00, busy: 1'b0, done: 1'b0});
      @(negedge clk) reset = 1'b0;
      foreach (vecs[i])
         step($sformatf("vec%0d", i), vecs[i].mode, vecs[i].d, vecs[i].sin_r, vecs[i].sin_l,
              vecs[i].en, 1'b0, vecs[i].exp_q, 1'b0, 1'b0);
      // plain burst, then a stalled burst with LOAD/start noise while busy
      burst(8'hB4, 0, 0, 1'b0);
      burst(8'hB4, 3, 3, 1'b1);
      // reset after the 4th bit aborts without a done pulse
      step("abort0", 3'd0, 8'hB4, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB4, 1'b1, 1'b0);
      for (int k = 1; k < 4; k++)
         step("abort", 3'd0, 8'hB4, 1'b0, 1'b0, 1'b1, 1'b0, 8'(8'hB4 << k), 1'b1, 1'b0);
      @(negedge clk) reset = 1'b1;
      #1 check_all("abort_rst", '{q: 8'h00, busy: 1'b0, done: 1'b0});
      @(negedge clk) reset = 1'b0;
      for (int k = 0; k < 10; k++)
         step("no_done", 3'd0, 8'hB4, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      burst(8'h5A, 0, 0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
